// File: rtl/multi_channel_timer.sv
// Bank of NUM_CH independent programmable timers: reloadable, up/down,
// one-shot or periodic. Terminal-count pulses are registered.
module multi_channel_timer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH-1:0]       cfg_dir,
    input  logic [NUM_CH-1:0]       cfg_mode,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc_pulse,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       busy,
    output logic                    any_tc
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    logic [NUM_CH-1:0] w_tc_all;
    logic              r_any_tc;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] r_reload, w_reload_d;
        logic [WIDTH-1:0] r_count, w_count_d;
        logic             r_dir, w_dir_d;
        logic             r_mode, w_mode_d;
        logic             r_tc, w_tc_d;
        state_e           r_state, w_state_d;
        logic [WIDTH-1:0] w_init, w_term, w_base, w_step, w_lv;

        assign w_lv   = load_val[g*WIDTH +: WIDTH];
        assign w_init = r_dir ? '0 : r_reload;
        assign w_term = r_dir ? r_reload : '0;
        // A start from DONE re-arms from init; from IDLE it resumes the held count.
        assign w_base = (r_state == StDone) ? w_init : r_count;
        assign w_step = r_dir ? r_count + WIDTH'(1) : r_count - WIDTH'(1);

        always_comb begin
            w_reload_d = r_reload;
            w_count_d  = r_count;
            w_dir_d    = r_dir;
            w_mode_d   = r_mode;
            w_state_d  = r_state;
            w_tc_d     = 1'b0;
            if (load[g]) begin
                w_reload_d = w_lv;
                w_dir_d    = cfg_dir[g];
                w_mode_d   = cfg_mode[g];
                w_count_d  = cfg_dir[g] ? '0 : w_lv;
                w_state_d  = StIdle;
            end else if (stop[g]) begin
                if (r_state == StRun) begin
                    w_state_d = StIdle;
                end
            end else if (start[g]) begin
                if (r_state != StRun) begin
                    w_count_d = w_base;
                    if (w_base != w_term || r_mode) begin
                        w_state_d = StRun;
                    end else begin
                        w_state_d = StDone;
                        w_tc_d    = 1'b1;
                    end
                end
            end else if (tick && r_state == StRun) begin
                if (r_count != w_term) begin
                    w_count_d = w_step;
                    if (w_step == w_term) begin
                        w_tc_d = 1'b1;
                        if (!r_mode) begin
                            w_state_d = StDone;
                        end
                    end
                end else begin
                    // Periodic wrap at term; reload=0 makes init==term, so pulse again.
                    w_count_d = w_init;
                    w_tc_d    = (w_init == w_term);
                    if (!r_mode) begin
                        w_state_d = StDone;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_reload <= '0;
                r_count  <= '0;
                r_dir    <= 1'b0;
                r_mode   <= 1'b0;
                r_tc     <= 1'b0;
                r_state  <= StIdle;
            end else begin
                r_reload <= w_reload_d;
                r_count  <= w_count_d;
                r_dir    <= w_dir_d;
                r_mode   <= w_mode_d;
                r_tc     <= w_tc_d;
                r_state  <= w_state_d;
            end
        end

        assign w_tc_all[g]                = w_tc_d;
        assign count[g*WIDTH +: WIDTH]    = r_count;
        assign tc_pulse[g]                = r_tc;
        assign done[g]                    = (r_state == StDone);
        assign busy[g]                    = (r_state == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_tc <= 1'b0;
        end else begin
            r_any_tc <= |w_tc_all;
        end
    end

    assign any_tc = r_any_tc;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer (WIDTH=8, NUM_CH=4).
module tb_multi_channel_timer;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0;
    logic [N-1:0] load = '0, cfg_dir = '0, cfg_mode = '0, start = '0, stop = '0;
    logic [N*W-1:0] load_val = '0;
    logic [N*W-1:0] count;
    logic [N-1:0] tc_pulse, done, busy;
    logic         any_tc;

    int total = 0;
    int bad = 0;

    multi_channel_timer #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
        .cfg_dir(cfg_dir), .cfg_mode(cfg_mode), .start(start), .stop(stop),
        .count(count), .tc_pulse(tc_pulse), .done(done), .busy(busy), .any_tc(any_tc)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] cnt(input int ch);
        return count[ch*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int ch, input logic [W-1:0] v, input logic d, input logic m);
        load[ch] = 1'b1;
        load_val[ch*W +: W] = v;
        cfg_dir[ch] = d;
        cfg_mode[ch] = m;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (count !== '0 || tc_pulse !== '0 || done !== '0 || busy !== '0 || any_tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: count=%h tc=%b done=%b busy=%b any=%b want all 0",
                     count, tc_pulse, done, busy, any_tc);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_down_oneshot();
        logic [W-1:0] exp_c [5] = '{4, 3, 2, 1, 0};
        do_load(0, 8'd5, 1'b0, 1'b0);
        step();
        load = '0;
        total++;
        if (cnt(0) !== 8'd5 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL os_load: count=%0d busy=%b want 5 0", cnt(0), busy[0]);
        end
        start[0] = 1'b1;
        step();
        start = '0;
        total++;
        if (cnt(0) !== 8'd5 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL os_start: count=%0d busy=%b want 5 1", cnt(0), busy[0]);
        end
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (cnt(0) !== exp_c[i] || tc_pulse[0] !== (i == 4)) begin
                bad++;
                $display("FAIL os_count[%0d]: count=%0d tc=%b want %0d %b",
                         i, cnt(0), tc_pulse[0], exp_c[i], (i == 4));
            end
        end
        total++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL os_done: done=%b busy=%b want 1 0", done[0], busy[0]);
        end
        step();
        step();
        tick = 1'b0;
        total++;
        if (cnt(0) !== 8'd0 || tc_pulse[0] !== 1'b0 || done[0] !== 1'b1) begin
            bad++;
            $display("FAIL os_hold: count=%0d tc=%b done=%b want 0 0 1",
                     cnt(0), tc_pulse[0], done[0]);
        end
    endtask

    task automatic test_up_periodic();
        logic [W-1:0] exp_c [16] = '{1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        do_load(1, 8'd3, 1'b1, 1'b1);
        step();
        load = '0;
        start[1] = 1'b1;
        step();
        start = '0;
        total++;
        if (cnt(1) !== 8'd0 || busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL up_start: count=%0d busy=%b want 0 1", cnt(1), busy[1]);
        end
        for (int i = 0; i < 16; i++) begin
            tick = (i % 2 == 0);
            step();
            total++;
            if (cnt(1) !== exp_c[i] || tc_pulse[1] !== (i == 4 || i == 12)
                || any_tc !== (i == 4 || i == 12)) begin
                bad++;
                $display("FAIL up_seq[%0d]: count=%0d tc=%b any=%b want %0d %b",
                         i, cnt(1), tc_pulse[1], any_tc, exp_c[i], (i == 4 || i == 12));
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_pause_priority();
        do_load(2, 8'd10, 1'b0, 1'b0);
        step();
        load = '0;
        start[2] = 1'b1;
        step();
        start = '0;
        tick = 1'b1;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (cnt(2) !== 8'd6) begin
            bad++;
            $display("FAIL pr_run: count=%0d want 6", cnt(2));
        end
        stop[2] = 1'b1;
        step();
        stop = '0;
        for (int i = 0; i < 5; i++) step();
        total++;
        if (cnt(2) !== 8'd6 || busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL pr_stop: count=%0d busy=%b want 6 0", cnt(2), busy[2]);
        end
        start[2] = 1'b1;
        step();
        start = '0;
        total++;
        if (cnt(2) !== 8'd6 || busy[2] !== 1'b1) begin
            bad++;
            $display("FAIL pr_resume: count=%0d busy=%b want 6 1", cnt(2), busy[2]);
        end
        step();
        total++;
        if (cnt(2) !== 8'd5) begin
            bad++;
            $display("FAIL pr_resume_tick: count=%0d want 5", cnt(2));
        end
        do_load(2, 8'd9, 1'b0, 1'b0);
        start[2] = 1'b1;
        step();
        load = '0;
        start = '0;
        step();
        tick = 1'b0;
        total++;
        if (cnt(2) !== 8'd9 || busy[2] !== 1'b0 || done[2] !== 1'b0) begin
            bad++;
            $display("FAIL pr_load_start: count=%0d busy=%b done=%b want 9 0 0",
                     cnt(2), busy[2], done[2]);
        end
    endtask

    task automatic test_boundaries();
        int ntc;
        do_load(3, 8'd0, 1'b0, 1'b1);
        step();
        load = '0;
        start[3] = 1'b1;
        step();
        start = '0;
        total++;
        if (busy[3] !== 1'b1 || tc_pulse[3] !== 1'b0) begin
            bad++;
            $display("FAIL r0p_start: busy=%b tc=%b want 1 0", busy[3], tc_pulse[3]);
        end
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (tc_pulse[3] !== 1'b1 || cnt(3) !== 8'd0) begin
                bad++;
                $display("FAIL r0p_tick[%0d]: tc=%b count=%0d want 1 0", i, tc_pulse[3], cnt(3));
            end
        end
        tick = 1'b0;
        step();
        total++;
        if (tc_pulse[3] !== 1'b0) begin
            bad++;
            $display("FAIL r0p_idle_tick: tc=%b want 0", tc_pulse[3]);
        end
        do_load(2, 8'd0, 1'b0, 1'b0);
        step();
        load = '0;
        start[2] = 1'b1;
        step();
        start = '0;
        total++;
        if (done[2] !== 1'b1 || tc_pulse[2] !== 1'b1 || busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL r0o_start: done=%b tc=%b busy=%b want 1 1 0",
                     done[2], tc_pulse[2], busy[2]);
        end
        step();
        total++;
        if (done[2] !== 1'b1 || tc_pulse[2] !== 1'b0) begin
            bad++;
            $display("FAIL r0o_after: done=%b tc=%b want 1 0", done[2], tc_pulse[2]);
        end
        do_load(3, 8'd255, 1'b1, 1'b1);
        step();
        load = '0;
        start[3] = 1'b1;
        step();
        start = '0;
        tick = 1'b1;
        ntc = 0;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (tc_pulse[3]) ntc++;
            if (k == 1 || k == 128 || k == 254) begin
                total++;
                if (cnt(3) !== W'(k) || tc_pulse[3] !== 1'b0) begin
                    bad++;
                    $display("FAIL full_up[%0d]: count=%0d tc=%b want %0d 0",
                             k, cnt(3), tc_pulse[3], k);
                end
            end
            if (k == 255) begin
                total++;
                if (cnt(3) !== 8'd255 || tc_pulse[3] !== 1'b1) begin
                    bad++;
                    $display("FAIL full_up_top: count=%0d tc=%b want 255 1", cnt(3), tc_pulse[3]);
                end
            end
            if (k == 256) begin
                total++;
                if (cnt(3) !== 8'd0 || tc_pulse[3] !== 1'b0) begin
                    bad++;
                    $display("FAIL full_up_wrap: count=%0d tc=%b want 0 0", cnt(3), tc_pulse[3]);
                end
            end
        end
        tick = 1'b0;
        total++;
        if (ntc !== 1) begin
            bad++;
            $display("FAIL full_up_pulses: got=%0d want 1", ntc);
        end
    endtask

    task automatic test_async_reset();
        do_load(0, 8'd5, 1'b0, 1'b0);
        do_load(1, 8'd9, 1'b0, 1'b1);
        step();
        load = '0;
        start[0] = 1'b1;
        start[1] = 1'b1;
        step();
        start = '0;
        tick = 1'b1;
        step();
        step();
        total++;
        if (cnt(0) !== 8'd3 || cnt(1) !== 8'd7) begin
            bad++;
            $display("FAIL ar_pre: ch0=%0d ch1=%0d want 3 7", cnt(0), cnt(1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (count !== '0 || busy !== '0 || done !== '0 || tc_pulse !== '0 || any_tc !== 1'b0) begin
            bad++;
            $display("FAIL ar_immediate: count=%h busy=%b done=%b tc=%b want all 0",
                     count, busy, done, tc_pulse);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        total++;
        if (count !== '0 || busy !== '0) begin
            bad++;
            $display("FAIL ar_no_count: count=%h busy=%b want 0 0", count, busy);
        end
        tick = 1'b0;
        do_load(0, 8'd4, 1'b0, 1'b0);
        step();
        load = '0;
        start[0] = 1'b1;
        step();
        start = '0;
        tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick = 1'b0;
        total++;
        if (cnt(0) !== 8'd1 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL ar_restart: count=%0d busy=%b want 1 1", cnt(0), busy[0]);
        end
    endtask

    task automatic test_rearm_indep();
        logic [W-1:0] e0 [9] = '{3, 2, 1, 0, 0, 0, 0, 0, 0};
        logic [W-1:0] e3 [9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
        logic [8:0]   t0 = 9'b000001000;
        logic [8:0]   t3 = 9'b010010010;
        tick = 1'b1;
        step();
        tick = 1'b0;
        total++;
        if (done[0] !== 1'b1 || cnt(0) !== 8'd0) begin
            bad++;
            $display("FAIL ri_done: done=%b count=%0d want 1 0", done[0], cnt(0));
        end
        do_load(3, 8'd2, 1'b0, 1'b1);
        step();
        load = '0;
        start[0] = 1'b1;
        start[3] = 1'b1;
        step();
        start = '0;
        total++;
        if (cnt(0) !== 8'd4 || busy[0] !== 1'b1 || done[0] !== 1'b0 || cnt(3) !== 8'd2) begin
            bad++;
            $display("FAIL ri_rearm: ch0=%0d busy=%b done=%b ch3=%0d want 4 1 0 2",
                     cnt(0), busy[0], done[0], cnt(3));
        end
        tick = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if (cnt(0) !== e0[i] || cnt(3) !== e3[i] || tc_pulse[0] !== t0[i]
                || tc_pulse[3] !== t3[i] || any_tc !== (t0[i] | t3[i])) begin
                bad++;
                $display("FAIL ri_seq[%0d]: ch0=%0d ch3=%0d tc0=%b tc3=%b any=%b want %0d %0d %b %b",
                         i, cnt(0), cnt(3), tc_pulse[0], tc_pulse[3], any_tc,
                         e0[i], e3[i], t0[i], t3[i]);
            end
        end
        tick = 1'b0;
        total++;
        if (done[0] !== 1'b1 || busy[3] !== 1'b1) begin
            bad++;
            $display("FAIL ri_end: done0=%b busy3=%b want 1 1", done[0], busy[3]);
        end
    endtask

    initial begin
        test_reset();
        test_down_oneshot();
        test_up_periodic();
        test_pause_priority();
        test_boundaries();
        test_async_reset();
        test_rearm_indep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_timer.md
Name: multi_channel_timer

Overview:
NUM_CH independent programmable counters/timers of WIDTH bits, sharing one clock and one count-tick input. This generalises the simple enable-gated down counter with the following:
- per-channel reload value
- up or down direction
- one-shot or periodic mode
- start/stop control
- registered terminal-count pulses

Used as the common timer resource for timeout, PWM-period and event-interval generation.

Parameters:
WIDTH, 8, counter/reload width per channel (>=2)
NUM_CH, 4, number of independent channels (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
tick  in  1  shared count-enable strobe; counting occurs only on clk edges where tick=1
load  in  NUM_CH  per-channel load strobe
load_val  in  NUM_CH*WIDTH  reload values, channel i at [i*WIDTH +: WIDTH]
cfg_dir  in  NUM_CH  direction captured on load: 0=down, 1=up
cfg_mode  in  NUM_CH  mode captured on load: 0=one-shot, 1=periodic
start  in  NUM_CH  per-channel start strobe
stop  in  NUM_CH  per-channel stop (pause) strobe
count  out  NUM_CH*WIDTH  current count per channel, same packing as load_val
tc_pulse  out  NUM_CH  one-cycle terminal-count pulse
done  out  NUM_CH  one-shot expired (level)
busy  out  NUM_CH  channel in RUN state
any_tc  out  1  OR of tc_pulse

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous, any time including mid-count) clears the following:
  - count=0, reload reg=0, dir=0, mode=0
  - state=IDLE
  - tc_pulse=0, done=0, busy=0, any_tc=0
- Per-channel registers: reload[WIDTH], dir, mode, count[WIDTH], state.
- init value: down gives reload; up gives 0.
- term value: down gives 0; up gives reload.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE). Both are decoded from registered state, so there are no combinational paths from inputs to outputs.
- Per-channel priority on each edge: load > stop > start > tick.
- load: reload<=load_val, dir<=cfg_dir, mode<=cfg_mode, count<=init (computed from the new values), state<=IDLE. Any same-cycle start/stop/tick is ignored.
- stop: RUN->IDLE, count held. Ignored in IDLE/DONE.
- start from IDLE: if count!=term, go RUN with count unchanged (resume after stop). If count==term:
  - one-shot: go DONE and tc_pulse next cycle.
  - periodic: go RUN.
- start from DONE: count<=init, then apply the same IDLE rule. A second start re-arms the one-shot.
- start in RUN: ignored.
- tick in RUN, count!=term: count steps by one toward term (down: -1, up: +1). If the new count==term:
  - tc_pulse=1 on the following cycle (registered, coincident with count==term).
  - one-shot: state<=DONE on the same edge; count holds term.
- tick in RUN, count==term (periodic only): count<=init. If init==term (reload=0), tc_pulse again.
- Periodic period is reload+1 ticks; reload=0 gives a tc_pulse on every tick.
- tick in IDLE/DONE: no effect.
- Wrap: count never passes term.
- Reload value is modulo 2^WIDTH.
- Up mode with reload=2^WIDTH-1 counts the full range.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- tc_pulse is high for exactly one clk cycle per terminal event, even when tick is held high continuously.
- any_tc is registered (OR of next tc_pulse values), aligned with tc_pulse.

Test Plan:
1. Down/one-shot, WIDTH=8: load 5 on ch0, start, tick every cycle.
   - count goes 5,4,3,2,1,0.
   - tc_pulse[0] for one cycle when count=0.
   - done[0]=1, busy[0]=0; count holds 0 under further ticks.
2. Up/periodic: load 3 on ch1, start, tick every 2nd cycle.
   - count sequence 0,1,2,3,0,1,...
   - tc_pulse[1] every 8 clk cycles (4 ticks).
   - any_tc matches tc_pulse[1].
3. Pause/resume and priority:
   - Ch2 down from 10; stop at count=6; ticks for 5 cycles give count=6, busy=0.
   - start resumes 6,5,...
   - load 9 and start in the same cycle gives count=9, state IDLE (start ignored).
4. Boundaries:
   - reload=0 periodic gives tc_pulse on every tick.
   - reload=0 one-shot start gives done next cycle plus one tc_pulse.
   - up reload=255 runs 256 ticks per period, no overflow past 255.
5. Async reset mid-count: assert rst_n=0 between clock edges while ch0=3 and ch1=7 are running.
   - All outputs go 0 immediately.
   - After release, ticks do not count until load+start.
6. Re-arm and independence:
   - start on a DONE ch0 reloads and reruns the full sequence.
   - Concurrently ch3 periodic load 2 pulses every 3 ticks, unaffected by ch0 events.
